pe_2d_seq_ctrl: RTL and testbench



---
 rtl/pe_2d_seq_ctrl_pkg.sv | 15 +
 rtl/pe_2d_seq_fsm.sv | 104 ++++++++++
 rtl/pe_2d_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pe_2d_seq_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_2d_seq_ctrl_pkg.sv
// Shared constants and state type for the PE_2D sequencer.
// The optional cycle counter is enabled with PE_2D_SEQ_CTRL_PERF_EN.
package pe_2d_seq_ctrl_pkg;

    localparam int conv4_width  = 8;
    localparam int PE_FLUSH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DONE
    } pe_seq_state_e;

endpackage

// File: rtl/pe_2d_seq_fsm.sv
// Control FSM for the PE_2D sequencer: state register, pair/flush counters and
// the sticky timeout flag. Datapath registers live in the top level.
module pe_2d_seq_fsm
    import pe_2d_seq_ctrl_pkg::*;
#(
    parameter int LEN_W     = 4,
    parameter int FLUSH_MAX = PE_FLUSH_MAX
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic             pe_flag,
    input  logic             out_ready,
    output pe_seq_state_e    state_o,
    output logic             accept_o,
    output logic             capture_o,
    output logic             timeout_o,
    output logic             result_hs_o,
    output logic             err_timeout_o
);

    localparam int FW = $clog2(FLUSH_MAX + 1);

    pe_seq_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic             err_timeout_q, err_timeout_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            len_q         <= '0;
            pair_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            pair_cnt_q    <= pair_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        pair_cnt_d    = pair_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        err_timeout_d = err_timeout_q;
        accept_o      = 1'b0;
        capture_o     = 1'b0;
        timeout_o     = 1'b0;
        result_hs_o   = 1'b0;

        case (state_q)
            IDLE: begin
                // A zero-length job has nothing to feed, so it is dropped here.
                if (start && (len != '0)) begin
                    len_d         = len;
                    pair_cnt_d    = '0;
                    flush_cnt_d   = '0;
                    err_timeout_d = 1'b0;
                    state_d       = FEED;
                end
            end
            FEED: begin
                if (in_valid) begin
                    accept_o   = 1'b1;
                    pair_cnt_d = pair_cnt_q + LEN_W'(1);
                    if (pair_cnt_d == len_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                // A flag arriving on the last allowed cycle still yields a result.
                if (pe_flag) begin
                    capture_o = 1'b1;
                    state_d   = DONE;
                end else if (flush_cnt_d == FW'(FLUSH_MAX)) begin
                    timeout_o     = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    result_hs_o = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o       = state_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: rtl/pe_2d_seq_ctrl.sv
// Sequencer for one PE_2D element: feeds operand pairs, flushes with zeros until
// o_flag, then holds the captured dot product. Optional: PE_2D_SEQ_CTRL_PERF_EN.
module pe_2d_seq_ctrl
    import pe_2d_seq_ctrl_pkg::*;
#(
    parameter int DW        = conv4_width,
    parameter int LEN_W     = 4,
    parameter int FLUSH_MAX = PE_FLUSH_MAX
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [LEN_W-1:0] len,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic            pe_en,
    output logic [DW-1:0]   pe_r1,
    output logic [DW-1:0]   pe_r2,
    input  logic [2*DW-1:0] pe_mat,
    input  logic            pe_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic            err_timeout
`ifdef PE_2D_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);

    // Both streams transfer on a cycle where valid && ready; a source holds its
    // payload until then, and ready never depends combinationally on valid.
    pe_seq_state_e state;
    logic          accept;
    logic          capture;
    logic          timeout;
    logic          result_hs;

    pe_2d_seq_fsm #(
        .LEN_W     (LEN_W),
        .FLUSH_MAX (FLUSH_MAX)
    ) u_fsm (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .len           (len),
        .in_valid      (in_valid),
        .pe_flag       (pe_flag),
        .out_ready     (out_ready),
        .state_o       (state),
        .accept_o      (accept),
        .capture_o     (capture),
        .timeout_o     (timeout),
        .result_hs_o   (result_hs),
        .err_timeout_o (err_timeout)
    );

    assign busy     = (state != IDLE);
    assign in_ready = (state == FEED);

    logic            pe_en_q, pe_en_d;
    logic [DW-1:0]   pe_r1_q, pe_r1_d;
    logic [DW-1:0]   pe_r2_q, pe_r2_d;
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] out_data_q, out_data_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_en_q     <= 1'b0;
            pe_r1_q     <= '0;
            pe_r2_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pe_en_q     <= pe_en_d;
            pe_r1_q     <= pe_r1_d;
            pe_r2_q     <= pe_r2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        pe_en_d     = 1'b0;
        pe_r1_d     = pe_r1_q;
        pe_r2_d     = pe_r2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state)
            FEED: begin
                // Bubbles leave the operand registers alone; only en drops.
                if (accept) begin
                    pe_en_d = 1'b1;
                    pe_r1_d = in_a;
                    pe_r2_d = in_b;
                end
            end
            FLUSH: begin
                pe_r1_d = '0;
                pe_r2_d = '0;
                pe_en_d = !(capture || timeout);
                if (capture) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pe_mat;
                end
            end
            DONE: begin
                if (result_hs) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign pe_en     = pe_en_q;
    assign pe_r1     = pe_r1_q;
    assign pe_r2     = pe_r2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef PE_2D_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_inc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cnt_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_cnt_q    <= perf_cnt_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    // The latched value includes the cycle in which the job ends.
    always_comb begin
        perf_inc      = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
        perf_cnt_d    = perf_cnt_q;
        perf_cycles_d = perf_cycles_q;
        if (state == IDLE) begin
            if (start && (len != '0)) begin
                perf_cnt_d = '0;
            end
        end else begin
            perf_cnt_d = perf_inc;
        end
        if (result_hs || timeout) begin
            perf_cycles_d = perf_inc;
        end
    end

    assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_pe_2d_seq_ctrl.sv
// Self-checking bench for pe_2d_seq_ctrl with a behavioural PE_2D that flags
// two cycles into the flush with its running sum.
module tb_pe_2d_seq_ctrl;
    import pe_2d_seq_ctrl_pkg::*;

    localparam int DW    = conv4_width;
    localparam int LEN_W = 4;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [LEN_W-1:0] len;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            pe_en;
    logic [DW-1:0]   pe_r1;
    logic [DW-1:0]   pe_r2;
    logic [2*DW-1:0] pe_mat;
    logic            pe_flag;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic            err_timeout;
`ifdef PE_2D_SEQ_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    pe_2d_seq_ctrl #(.DW(DW), .LEN_W(LEN_W), .FLUSH_MAX(PE_FLUSH_MAX)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .pe_en       (pe_en),
        .pe_r1       (pe_r1),
        .pe_r2       (pe_r2),
        .pe_mat      (pe_mat),
        .pe_flag     (pe_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err_timeout (err_timeout)
`ifdef PE_2D_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural PE_2D ----------------
    int              pe_len;
    bit              pe_hang;
    logic [2*DW-1:0] pe_acc;
    int              pe_cnt;

    assign pe_mat = pe_acc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_acc  <= '0;
            pe_cnt  <= 0;
            pe_flag <= 1'b0;
        end else if (pe_flag) begin
            pe_flag <= 1'b0;
            pe_acc  <= '0;
            pe_cnt  <= 0;
        end else if (!busy && !pe_en) begin
            pe_acc <= '0;
            pe_cnt <= 0;
        end else if (pe_en) begin
            pe_acc <= pe_acc + ({{DW{1'b0}}, pe_r1} * {{DW{1'b0}}, pe_r2});
            pe_cnt <= pe_cnt + 1;
            if (!pe_hang && (pe_cnt + 1 == pe_len + 1)) pe_flag <= 1'b1;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] op_q[$];
    logic [DW-1:0]   job_a[16];
    logic [DW-1:0]   job_b[16];
    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;
    bit en_seen = 0;
    int gap_cnt = 0;
    int flush_cyc = 0;
    int flush_en_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic monitor();
        logic [2*DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rstn || !mon_en) begin
                en_seen = 0;
            end else begin
                if (!busy) en_seen = 0;
                if (pe_en) begin
                    if (op_q.size() > 0) begin
                        e = op_q.pop_front();
                        check("pe_operands", {pe_r1, pe_r2}, e);
                    end else begin
                        check("flush_operands", {pe_r1, pe_r2}, 0);
                        flush_en_cnt++;
                    end
                    en_seen = 1;
                end else if (in_ready && en_seen) begin
                    gap_cnt++;
                end
                if (busy && !in_ready && !out_valid) flush_cyc++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", out_data, e);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_outputs_zero(input string tag);
        check(tag, {busy, in_ready, pe_en, pe_r1, pe_r2, out_valid, out_data, err_timeout}, 0);
    endtask

    task automatic feed_pairs(input int n, input int gap_at, input int gap_len,
                              input bit glitch, output int exp_gap);
        int  i;
        int  gaps;
        int  budget;
        bit  hs;
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("started", busy, 1);
        check("err_cleared", err_timeout, 0);
        i = 0; gaps = 0; exp_gap = 0; budget = 0;
        while (i < n && budget < 300) begin
            budget++;
            start = glitch && (i == 1);
            len   = glitch ? LEN_W'($urandom_range(0, 15)) : LEN_W'(n);
            if (i == gap_at && gaps < gap_len) begin
                in_valid = 1'b0;
                gaps++;
                if (i >= 1) exp_gap++;
            end else begin
                in_valid = 1'b1;
                in_a     = job_a[i];
                in_b     = job_b[i];
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (budget >= 300) check("feed_budget", 0, 1);
    endtask

    task automatic drive_job(input int n, input int gap_at, input int gap_len,
                             input int rdy_wait, input bit glitch, input bit expect_to);
        logic [2*DW-1:0] sum;
        logic [2*DW-1:0] held;
        int b_gap, b_fc, b_fe, exp_gap, budget;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            sum = sum + ({{DW{1'b0}}, job_a[k]} * {{DW{1'b0}}, job_b[k]});
            op_q.push_back({job_a[k], job_b[k]});
        end
        if (!expect_to) exp_q.push_back(sum);
        pe_len  = n;
        pe_hang = expect_to;
        b_gap = gap_cnt; b_fc = flush_cyc; b_fe = flush_en_cnt;
        out_ready = (rdy_wait == 0);
        feed_pairs(n, gap_at, gap_len, glitch, exp_gap);
        if (rdy_wait > 0 && !expect_to) begin
            budget = 0;
            while (!out_valid && budget < 100) begin
                @(posedge clk); #1;
                budget++;
            end
            check("out_valid_seen", out_valid, 1);
            check("done_data", out_data, sum);
            held = out_data;
            repeat (rdy_wait) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("valid_drop", out_valid, 0);
        end
        budget = 0;
        while (busy && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("back_to_idle", busy, 0);
        check("flush_cycles", flush_cyc - b_fc, expect_to ? 16 : 3);
        check("flush_en_cycles", flush_en_cnt - b_fe, expect_to ? 15 : 2);
        check("bubble_cycles", gap_cnt - b_gap, exp_gap);
        check("ops_consumed", op_q.size(), 0);
        check("err_timeout", err_timeout, expect_to);
        check("out_valid_idle", out_valid, 0);
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1;
            check("no_queued_job", busy, 0);
        end
    endtask

    task automatic load_seq4();
        for (int k = 0; k < 4; k++) begin
            job_a[k] = DW'(k + 1);
            job_b[k] = DW'(k + 3);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, ga, exp_gap, budget;
        rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0; pe_len = 0; pe_hang = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rstn = 1'b1;
        fork
            monitor();
        join_none
        mon_en = 1;
        @(posedge clk); #1;

        // Back-to-back, with bubbles, with a stalled consumer.
        load_seq4();
        drive_job(4, -1, 0, 0, 0, 0);
        drive_job(4, 2, 2, 0, 0, 0);
        drive_job(4, -1, 0, 5, 0, 0);

        // Zero-length start is dropped; a start during FEED changes nothing.
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_ignored", busy, 0);
        @(posedge clk); #1;
        check("len0_still_idle", busy, 0);
        drive_job(4, -1, 0, 1, 1, 0);

        // PE never flags.
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
            job_a[k] = DW'($urandom_range(0, 255));
            job_b[k] = DW'($urandom_range(0, 255));
        end
        drive_job(n, -1, 0, 0, 0, 1);
        pe_hang = 0;

        // Reset in the middle of FEED.
        mon_en = 0;
        pe_len = 4; out_ready = 1'b1;
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("busy_before_rst", busy, 1);
        rstn = 1'b0; #1;
        check_outputs_zero("reset_mid_feed");
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        // Reset while a result waits in DONE.
        job_a[0] = 8'd5; job_b[0] = 8'd7; job_a[1] = 8'd6; job_b[1] = 8'd8;
        pe_len = 2; out_ready = 1'b0;
        feed_pairs(2, -1, 0, 0, exp_gap);
        budget = 0;
        while (!out_valid && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("done_before_rst", out_valid, 1);
        #2;
        rstn = 1'b0; #1;
        check_outputs_zero("reset_mid_done");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;
        drive_job(2, -1, 0, 1, 0, 0);

        // Boundary: longest job with the largest operands.
        for (int k = 0; k < 15; k++) begin
            job_a[k] = 8'hFF;
            job_b[k] = 8'hFF;
        end
        drive_job(15, -1, 0, 0, 0, 0);
        job_a[0] = DW'($urandom_range(0, 255));
        job_b[0] = DW'($urandom_range(0, 255));
        drive_job(1, -1, 0, 2, 0, 0);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(1, 15);
            for (int k = 0; k < n; k++) begin
                job_a[k] = DW'($urandom_range(0, 255));
                job_b[k] = DW'($urandom_range(0, 255));
            end
            ga = (n > 1) ? $urandom_range(1, n - 1) : -1;
            drive_job(n, ga, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)) && (n > 1), 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
